// File: rtl/warp_divergence_stack_if.sv
// Operation/response bundle for the per-warp divergence stack.
// The master side issues strobes and data; the slave side returns read data and status.
interface warp_divergence_stack_if #(
    parameter int NUM_WARPS   = 4,
    parameter int STACK_WIDTH = 72
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [WID_W-1:0]       warp_id;
    logic [STACK_WIDTH-1:0] data_in;
    logic                   push;
    logic                   pop;
    logic                   push_back;
    logic                   read_tos;
    logic                   flush;
    logic [WID_W-1:0]       flush_warp_id;

    logic                   data_vld;
    logic [STACK_WIDTH-1:0] data_out;
    logic [WID_W-1:0]       data_warp_id;
    logic [NUM_WARPS-1:0]   stack_full;
    logic [NUM_WARPS-1:0]   stack_empty;
    logic                   overflow_err;
    logic                   underflow_err;

    modport master (
        output warp_id, data_in, push, pop, push_back, read_tos, flush, flush_warp_id,
        input  data_vld, data_out, data_warp_id, stack_full, stack_empty,
               overflow_err, underflow_err
    );

    modport slave (
        input  warp_id, data_in, push, pop, push_back, read_tos, flush, flush_warp_id,
        output data_vld, data_out, data_warp_id, stack_full, stack_empty,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/warp_divergence_stack.sv
// Per-warp reconvergence stacks sharing one storage array addressed {warp, pointer}.
// One operation per cycle on the selected warp, one-cycle read latency, sticky error flags.
module warp_divergence_stack #(
    parameter int NUM_WARPS   = 4,
    parameter int STACK_DEPTH = 8,
    parameter int STACK_WIDTH = 72
) (
    input logic                    clk,
    input logic                    rst,
    warp_divergence_stack_if.slave bus
);
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ADR_W = WID_W + PTR_W;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_SWAP,
        OP_PUSH,
        OP_POP,
        OP_PUSH_BACK,
        OP_READ_TOS
    } op_e;

    logic [CNT_W-1:0]       count_q [NUM_WARPS];
    logic [CNT_W-1:0]       count_d [NUM_WARPS];
    logic [STACK_WIDTH-1:0] mem_q   [NUM_WARPS*STACK_DEPTH];

    logic                   dataVld_q, dataVld_d;
    logic [STACK_WIDTH-1:0] dataOut_q, dataOut_d;
    logic [WID_W-1:0]       dataWid_q, dataWid_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    op_e                    op;
    logic                   validWarp;
    logic                   flushHit;
    logic [CNT_W-1:0]       selCount;
    logic                   selEmpty;
    logic                   selFull;
    logic [PTR_W-1:0]       topPtr;
    logic                   memWe;
    logic [ADR_W-1:0]       memAddr;
    logic                   readEn;
    logic                   cntInc;
    logic                   cntDec;

    // Priority decode: swap beats push beats pop beats push_back beats read_tos.
    always_comb begin
        op = OP_IDLE;
        if (bus.push && bus.pop) begin
            op = OP_SWAP;
        end else if (bus.push) begin
            op = OP_PUSH;
        end else if (bus.pop) begin
            op = OP_POP;
        end else if (bus.push_back) begin
            op = OP_PUSH_BACK;
        end else if (bus.read_tos) begin
            op = OP_READ_TOS;
        end
    end

    assign validWarp = (int'(bus.warp_id) < NUM_WARPS);
    assign flushHit  = bus.flush && (bus.flush_warp_id == bus.warp_id);
    assign selCount  = validWarp ? count_q[bus.warp_id] : '0;
    assign selEmpty  = (selCount == '0);
    assign selFull   = (selCount == CNT_W'(STACK_DEPTH));
    assign topPtr    = PTR_W'(selCount - 1'b1);

    // Legality checks; a flush on the same warp silently cancels the operation.
    always_comb begin
        memWe       = 1'b0;
        memAddr     = {bus.warp_id, topPtr};
        readEn      = 1'b0;
        cntInc      = 1'b0;
        cntDec      = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (validWarp && !flushHit) begin
            unique case (op)
                OP_SWAP: begin
                    if (selEmpty) underflow_d = 1'b1;
                    else begin
                        readEn = 1'b1;
                        memWe  = 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (selFull) overflow_d = 1'b1;
                    else begin
                        memWe   = 1'b1;
                        memAddr = {bus.warp_id, selCount[PTR_W-1:0]};
                        cntInc  = 1'b1;
                    end
                end
                OP_POP: begin
                    if (selEmpty) underflow_d = 1'b1;
                    else begin
                        readEn = 1'b1;
                        cntDec = 1'b1;
                    end
                end
                OP_PUSH_BACK: begin
                    if (selEmpty) underflow_d = 1'b1;
                    else memWe = 1'b1;
                end
                OP_READ_TOS: begin
                    if (selEmpty) underflow_d = 1'b1;
                    else readEn = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) begin
            count_d[i] = count_q[i];
            if (bus.flush && (bus.flush_warp_id == WID_W'(i))) begin
                count_d[i] = '0;
            end else if (bus.warp_id == WID_W'(i)) begin
                if (cntInc) count_d[i] = count_q[i] + 1'b1;
                else if (cntDec) count_d[i] = count_q[i] - 1'b1;
            end
        end
    end

    // The read samples the pre-edge top, so a swap returns the old entry it overwrites.
    always_comb begin
        dataVld_d = readEn;
        dataOut_d = readEn ? mem_q[{bus.warp_id, topPtr}] : '0;
        dataWid_d = readEn ? bus.warp_id : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WARPS; i++) count_q[i] <= '0;
            dataVld_q   <= 1'b0;
            dataOut_q   <= '0;
            dataWid_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) count_q[i] <= count_d[i];
            dataVld_q   <= dataVld_d;
            dataOut_q   <= dataOut_d;
            dataWid_q   <= dataWid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; only the counts define what is live.
    always_ff @(posedge clk) begin
        if (memWe && !rst) begin
            mem_q[memAddr] <= bus.data_in;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) begin
            bus.stack_full[i]  = (count_q[i] == CNT_W'(STACK_DEPTH));
            bus.stack_empty[i] = (count_q[i] == '0);
        end
    end

    assign bus.data_vld      = dataVld_q;
    assign bus.data_out      = dataOut_q;
    assign bus.data_warp_id  = dataWid_q;
    assign bus.overflow_err  = overflow_q;
    assign bus.underflow_err = underflow_q;
endmodule
